// File: rtl/muldiv_wb_queue.sv
// Writeback queue for multi-cycle execution units: per-unit holding registers,
// a round-robin arbiter and an in-order result FIFO with per-unit flush.
module muldiv_wb_queue #(
    parameter int XLEN    = 32,
    parameter int N_UNITS = 2,
    parameter int DEPTH   = 4,
    parameter int RAW     = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [N_UNITS-1:0]           i_done,
    input  logic [N_UNITS*XLEN-1:0]      i_result,
    input  logic [N_UNITS*RAW-1:0]       i_rd_addr,
    input  logic [N_UNITS-1:0]           i_wren,
    input  logic [N_UNITS-1:0]           i_flush,
    output logic [N_UNITS-1:0]           o_hold_full,
    output logic [N_UNITS-1:0]           o_overrun,
    output logic                         o_wb_valid,
    output logic [XLEN-1:0]              o_wb_data,
    output logic [RAW-1:0]               o_wb_rd_addr,
    output logic                         o_wb_wren,
    output logic [$clog2(N_UNITS)-1:0]   o_wb_unit,
    input  logic                         i_wb_ready,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_stall
);
    localparam int UW = $clog2(N_UNITS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [N_UNITS-1:0] hold_valid;
    logic [XLEN-1:0]    hold_data [N_UNITS];
    logic [RAW-1:0]     hold_rd   [N_UNITS];
    logic [N_UNITS-1:0] hold_wren;

    logic [XLEN-1:0]    fifo_data [DEPTH];
    logic [RAW-1:0]     fifo_rd   [DEPTH];
    logic [UW-1:0]      fifo_unit [DEPTH];
    logic [DEPTH-1:0]   fifo_wren;
    logic [DEPTH-1:0]   entry_valid;

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [UW-1:0]      rr_ptr;

    logic               head_ev;
    logic               pop;
    logic               push;
    logic               space;
    logic [N_UNITS-1:0] eligible;
    logic [N_UNITS-1:0] grant;
    logic [N_UNITS-1:0] load;
    logic [UW-1:0]      gnt_idx;
    logic [UW-1:0]      rr_next;

    // Invalidated heads are discarded without waiting for the writeback stage.
    always_comb begin
        head_ev = entry_valid[rd_ptr];
        pop     = (count != '0) && (!head_ev || i_wb_ready);
        space   = (count < FULL) || pop;
    end

    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        gnt_idx  = '0;
        eligible = hold_valid & ~i_flush;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            idx = (32'(rr_ptr) + i) % N_UNITS;
            if (!found && space && eligible[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = UW'(idx);
                found      = 1'b1;
            end
        end
        push    = found;
        rr_next = (gnt_idx == UW'(N_UNITS - 1)) ? '0 : gnt_idx + UW'(1);
    end

    always_comb begin
        o_hold_full = hold_valid & ~grant;
        load        = i_done & ~i_flush & (~hold_valid | grant);
        o_stall     = (count == FULL) || (|hold_valid);
        o_count     = count;
        o_wb_valid  = (count != '0) && head_ev;
        o_wb_data    = o_wb_valid ? fifo_data[rd_ptr] : '0;
        o_wb_rd_addr = o_wb_valid ? fifo_rd[rd_ptr]   : '0;
        o_wb_wren    = o_wb_valid ? fifo_wren[rd_ptr] : 1'b0;
        o_wb_unit    = o_wb_valid ? fifo_unit[rd_ptr] : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_valid <= '0;
            o_overrun  <= '0;
        end else begin
            for (int unsigned k = 0; k < N_UNITS; k++) begin
                if (i_flush[k])
                    hold_valid[k] <= 1'b0;
                else if (load[k])
                    hold_valid[k] <= 1'b1;
                else if (grant[k])
                    hold_valid[k] <= 1'b0;
                if (i_done[k] && !i_flush[k] && o_hold_full[k])
                    o_overrun[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            if (load[k]) begin
                hold_data[k] <= i_result[k*XLEN +: XLEN];
                hold_rd[k]   <= i_rd_addr[k*RAW +: RAW];
                hold_wren[k] <= i_wren[k];
            end
        end
        if (push) begin
            fifo_data[wr_ptr] <= hold_data[gnt_idx];
            fifo_rd[wr_ptr]   <= hold_rd[gnt_idx];
            fifo_wren[wr_ptr] <= hold_wren[gnt_idx];
            fifo_unit[wr_ptr] <= gnt_idx;
        end
    end

    // A push always targets a non-flushed unit, so it overrides any stale-tag clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            entry_valid <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rr_ptr      <= '0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (i_flush[fifo_unit[e]])
                    entry_valid[e] <= 1'b0;
            end
            if (push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PW'(1);
                rr_ptr              <= rr_next;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_muldiv_wb_queue.sv
// Directed bench for muldiv_wb_queue with a writeback scoreboard.
module tb_muldiv_wb_queue;
    localparam int XLEN  = 32;
    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int RAW   = 5;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wren;
        logic        unit;
    } pkt_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N-1:0]        done;
    logic [N*XLEN-1:0]   result;
    logic [N*RAW-1:0]    rd_addr;
    logic [N-1:0]        wren;
    logic [N-1:0]        flush;
    logic                wb_ready;
    logic [N-1:0]        hold_full;
    logic [N-1:0]        overrun;
    logic                wb_valid;
    logic [XLEN-1:0]     wb_data;
    logic [RAW-1:0]      wb_rd;
    logic                wb_wren;
    logic                wb_unit;
    logic [2:0]          count;
    logic                stall;

    int   vectors    = 0;
    int   miscompares = 0;
    pkt_t sb[$];
    pkt_t mon_exp;

    always #5 clk = ~clk;

    muldiv_wb_queue #(.XLEN(XLEN), .N_UNITS(N), .DEPTH(DEPTH), .RAW(RAW)) dut (
        .i_clk(clk), .i_rst(rst), .i_done(done), .i_result(result),
        .i_rd_addr(rd_addr), .i_wren(wren), .i_flush(flush),
        .o_hold_full(hold_full), .o_overrun(overrun), .o_wb_valid(wb_valid),
        .o_wb_data(wb_data), .o_wb_rd_addr(wb_rd), .o_wb_wren(wb_wren),
        .o_wb_unit(wb_unit), .i_wb_ready(wb_ready), .o_count(count), .o_stall(stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        done  = '0;
        flush = '0;
    endtask

    task automatic drive_done(input int u, input logic [31:0] d, input logic [4:0] rd,
                              input logic we, input bit exp_out);
        pkt_t p;
        done[u]                = 1'b1;
        result[u*XLEN +: XLEN] = d;
        rd_addr[u*RAW +: RAW]  = rd;
        wren[u]                = we;
        p.data = d;
        p.rd   = rd;
        p.wren = we;
        p.unit = u[0];
        if (exp_out)
            sb.push_back(p);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (count == 3'd0 && !stall && sb.size() == 0)
                break;
            step();
        end
        chk("drain_count", count, 0);
        chk("drain_stall", stall, 0);
        chk("drain_scoreboard_left", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_hold_full"}, hold_full, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_wren"}, wb_wren, 0);
        chk({tag, "_wb_unit"}, wb_unit, 0);
    endtask

    // Every accepted writeback must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected_valid", wb_valid, 0);
            end else begin
                mon_exp = sb.pop_front();
                chk("wb_data", wb_data, mon_exp.data);
                chk("wb_rd", wb_rd, mon_exp.rd);
                chk("wb_wren", wb_wren, mon_exp.wren);
                chk("wb_unit", wb_unit, mon_exp.unit);
            end
        end
    end

    initial begin
        done = '0; flush = '0; wren = '0; result = '0; rd_addr = '0; wb_ready = 1'b1;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Simultaneous completions, then round-robin order reversal
        drive_done(0, 32'h11, 5'd1, 1'b1, 1'b1);
        drive_done(1, 32'h22, 5'd2, 1'b1, 1'b1);
        step();
        chk("pair_hold_full", hold_full, 2'b10);
        chk("pair_stall", stall, 1);
        step();
        chk("pair_first_valid", wb_valid, 1);
        chk("pair_first_data", wb_data, 32'h11);
        chk("pair_first_count", count, 1);
        step();
        chk("pair_second_data", wb_data, 32'h22);
        chk("pair_second_unit", wb_unit, 1);
        repeat (3) step();
        drive_done(0, 32'h33, 5'd4, 1'b0, 1'b1);
        repeat (4) step();
        drive_done(1, 32'h55, 5'd6, 1'b1, 1'b1);
        drive_done(0, 32'h44, 5'd5, 1'b1, 1'b1);
        step();
        chk("pair2_hold_full", hold_full, 2'b01);
        drain(20);

        // Single result, two-cycle latency
        drive_done(0, 32'h0000_00AB, 5'd3, 1'b1, 1'b1);
        step();
        chk("single_t1_valid", wb_valid, 0);
        chk("single_t1_hold_full", hold_full, 0);
        step();
        chk("single_t2_valid", wb_valid, 1);
        chk("single_t2_data", wb_data, 32'hAB);
        chk("single_t2_rd", wb_rd, 3);
        chk("single_t2_unit", wb_unit, 0);
        chk("single_t2_count", count, 1);
        step();
        chk("single_t3_count", count, 0);
        chk("single_t3_valid", wb_valid, 0);

        // Backpressure: fill FIFO and both holds, then overrun unit 0
        wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_done(i % 2, 32'hA0 + i, 5'(10 + i), 1'b1, 1'b1);
            step();
        end
        chk("bp_count", count, 4);
        chk("bp_stall", stall, 1);
        chk("bp_hold_full", hold_full, 2'b11);
        chk("bp_head_data", wb_data, 32'hA0);
        chk("bp_overrun_before", overrun, 0);
        drive_done(0, 32'hDEAD, 5'd20, 1'b1, 1'b0);
        step();
        chk("bp_overrun_after", overrun, 2'b01);
        chk("bp_head_stable", wb_data, 32'hA0);
        wb_ready = 1'b1;
        drain(30);
        chk("bp_overrun_sticky", overrun, 2'b01);

        // Flush unit 0 with u0, u1, u0 queued
        wb_ready = 1'b0;
        drive_done(0, 32'hF0, 5'd7, 1'b1, 1'b1);
        step();
        drive_done(1, 32'hF1, 5'd8, 1'b1, 1'b1);
        step();
        drive_done(0, 32'hF2, 5'd9, 1'b1, 1'b1);
        step();
        step();
        chk("flush_count_before", count, 3);
        chk("flush_head_before", wb_data, 32'hF0);
        flush[0] = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].unit == 1'b0)
                sb.delete(i);
        step();
        chk("flush_head_valid", wb_valid, 0);
        chk("flush_count_after", count, 3);
        wb_ready = 1'b1;
        drain(20);

        // Asynchronous reset with three entries queued
        wb_ready = 1'b0;
        drive_done(0, 32'hC0, 5'd1, 1'b1, 1'b1);
        step();
        drive_done(1, 32'hC1, 5'd2, 1'b1, 1'b1);
        step();
        drive_done(0, 32'hC2, 5'd3, 1'b1, 1'b1);
        step();
        step();
        chk("rst_pre_count", count, 3);
        chk("rst_pre_valid", wb_valid, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        wb_ready = 1'b1;
        drive_done(1, 32'hCAFE_F00D, 5'd31, 1'b1, 1'b1);
        step();
        chk("post_rst_t1_valid", wb_valid, 0);
        step();
        chk("post_rst_t2_valid", wb_valid, 1);
        chk("post_rst_t2_data", wb_data, 32'hCAFE_F00D);
        chk("post_rst_t2_unit", wb_unit, 1);
        step();
        chk("post_rst_t3_count", count, 0);
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
